// File: rtl/sig_capture_pkg.sv
// rtl/sig_capture_pkg.sv - shared state encoding and parameter limits for the signal capture core
package sig_capture_pkg;

    localparam int DATA_W_MAX = 256;
    localparam int DEPTH_MIN  = 16;
    localparam int DEPTH_MAX  = 8192;
    localparam int TRIG_W_MAX = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } cap_state_e;

endpackage

// File: rtl/cap_ram.sv
// rtl/cap_ram.sv - simple dual-port sample buffer with one-cycle registered read, no reset
module cap_ram #(
    parameter int DATA_W = 40,
    parameter int DEPTH  = 512,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read data only moves on re_i, so it doubles as the readout holding register.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sig_capture_core.sv
// rtl/sig_capture_core.sv - triggered pre/post sample capture with streaming readout
module sig_capture_core
    import sig_capture_pkg::*;
#(
    parameter  int DATA_W = 40,
    parameter  int DEPTH  = 512,
    parameter  int TRIG_W = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              sample_en_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic [TRIG_W-1:0] trig_en_i,
    input  logic [TRIG_W-1:0] trig_edge_i,
    input  logic [TRIG_W-1:0] trig_pol_i,
    input  logic              trig_any_i,
    input  logic [AW-1:0]     pre_cnt_i,
    input  logic              arm_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              triggered_o,
    output logic              done_o,
    output logic [AW-1:0]     trig_pos_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic              rd_last_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    cap_state_e        state_q, state_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     pre_q, pre_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic [AW:0]       rd_left_q, rd_left_d;
    logic [TRIG_W-1:0] en_q, en_d;
    logic [TRIG_W-1:0] edge_q, edge_d;
    logic [TRIG_W-1:0] pol_q, pol_d;
    logic [TRIG_W-1:0] prev_q, prev_d;
    logic              any_q, any_d;
    logic              busy_q, busy_d;
    logic              triggered_q, triggered_d;
    logic              done_q, done_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;

    logic              ram_we, ram_re, enter_done;
    logic [DATA_W-1:0] ram_rdata;
    logic [TRIG_W-1:0] ch_match;
    logic              trig_hit;

    // Edge term: given trig==pol, "previous != pol" is the same as "previous != current".
    always_comb begin
        ch_match = ~(trig_i ^ pol_q) & (~edge_q | (trig_i ^ prev_q));
        trig_hit = (en_q == '0) ||
                   (any_q ? |(ch_match & en_q) : &(ch_match | ~en_q));
    end

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        rd_addr_d   = rd_addr_q;
        rd_left_d   = rd_left_q;
        en_d        = en_q;
        edge_d      = edge_q;
        pol_d       = pol_q;
        prev_d      = prev_q;
        any_d       = any_q;
        busy_d      = busy_q;
        triggered_d = triggered_q;
        done_d      = done_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        enter_done  = 1'b0;

        if (sample_en_i && (state_q == ST_FILL || state_q == ST_ARMED || state_q == ST_POST)) begin
            ram_we = 1'b1;
            wptr_d = wptr_q + AW'(1);
        end

        case (state_q)
            ST_FILL: begin
                if (sample_en_i) begin
                    prev_d = trig_i;
                    cnt_d  = cnt_q + AW'(1);
                    if (cnt_q + AW'(1) == pre_q) begin
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (sample_en_i) begin
                    prev_d = trig_i;
                    if (trig_hit) begin
                        triggered_d = 1'b1;
                        cnt_d       = '0;
                        if (pre_q == LAST_IDX) begin
                            enter_done = 1'b1;
                        end else begin
                            state_d = ST_POST;
                        end
                    end
                end
            end
            ST_POST: begin
                if (sample_en_i) begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q + AW'(1) == LAST_IDX - pre_q) begin
                        enter_done = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (rd_valid_q && rd_ready_i) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                end
                if (rd_left_q != '0 && (!rd_valid_q || rd_ready_i)) begin
                    ram_re     = 1'b1;
                    rd_addr_d  = rd_addr_q + AW'(1);
                    rd_left_d  = rd_left_q - (AW + 1)'(1);
                    rd_valid_d = 1'b1;
                    rd_last_d  = (rd_left_q == (AW + 1)'(1));
                end
            end
            default: ;
        endcase

        // After the final write the write pointer sits on the oldest retained sample.
        if (enter_done) begin
            state_d    = ST_DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            rd_addr_d  = wptr_q + AW'(1);
            rd_left_d  = FULL_CNT;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end

        // pre_cnt_i is AW bits wide, so it can never exceed DEPTH-1.
        if (arm_i && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            pre_d       = pre_cnt_i;
            en_d        = trig_en_i;
            edge_d      = trig_edge_i;
            pol_d       = trig_pol_i;
            any_d       = trig_any_i;
            wptr_d      = '0;
            cnt_d       = '0;
            prev_d      = '0;
            busy_d      = 1'b1;
            triggered_d = 1'b0;
            done_d      = 1'b0;
            rd_valid_d  = 1'b0;
            rd_last_d   = 1'b0;
            rd_left_d   = '0;
            state_d     = (pre_cnt_i == '0) ? ST_ARMED : ST_FILL;
        end

        if (abort_i) begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            triggered_d = 1'b0;
            done_d      = 1'b0;
            rd_valid_d  = 1'b0;
            rd_last_d   = 1'b0;
            rd_left_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            cnt_q       <= '0;
            pre_q       <= '0;
            rd_addr_q   <= '0;
            rd_left_q   <= '0;
            en_q        <= '0;
            edge_q      <= '0;
            pol_q       <= '0;
            prev_q      <= '0;
            any_q       <= 1'b0;
            busy_q      <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            rd_addr_q   <= rd_addr_d;
            rd_left_q   <= rd_left_d;
            en_q        <= en_d;
            edge_q      <= edge_d;
            pol_q       <= pol_d;
            prev_q      <= prev_d;
            any_q       <= any_d;
            busy_q      <= busy_d;
            triggered_q <= triggered_d;
            done_q      <= done_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    cap_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (wptr_q),
        .wdata_i (data_i),
        .re_i    (ram_re),
        .raddr_i (rd_addr_q),
        .rdata_o (ram_rdata)
    );

    assign busy_o      = busy_q;
    assign triggered_o = triggered_q;
    assign done_o      = done_q;
    assign trig_pos_o  = pre_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_last_o   = rd_last_q;
    assign rd_data_o   = rd_valid_q ? ram_rdata : '0;

endmodule

// File: doc/sig_capture_core.md
SIG_CAPTURE_CORE -- requirements
Module: sig_capture_core

Interface
REQ-001 Parameter DATA_W, default 40, captured sample width (1..256).
REQ-002 Parameter DEPTH, default 512, sample buffer depth, power of two, 16..8192; AW = log2(DEPTH).
REQ-003 Parameter TRIG_W, default 4, trigger channel count (1..16).
REQ-004 clk_i  in  1  sampling and control clock; all logic on rising edge.
REQ-005 rst_n_i  in  1  asynchronous, active-low reset.
REQ-006 data_i  in  DATA_W  probed data, sampled when sample_en_i=1.
REQ-007 sample_en_i  in  1  sample qualifier (decimation strobe); tie 1 for every-cycle capture.
REQ-008 trig_i  in  TRIG_W  trigger channels.
REQ-009 trig_en_i / trig_edge_i / trig_pol_i  in  TRIG_W each  per-channel enable, mode (0 level, 1 edge), polarity (1 high/rising, 0 low/falling).
REQ-010 trig_any_i  in  1  combine: 0 AND of enabled channels, 1 OR.
REQ-011 pre_cnt_i  in  AW  pre-trigger sample count, latched at arm.
REQ-012 arm_i / abort_i  in  1  single-cycle command pulses.
REQ-013 busy_o, triggered_o, done_o  out  1  status.
REQ-014 trig_pos_o  out  AW  read index of trigger sample (= latched pre count).
REQ-015 rd_data_o  out  DATA_W, rd_valid_o  out  1, rd_ready_i  in  1, rd_last_o  out  1  readout stream.

Function
REQ-016 States IDLE, FILL, ARMED, POST, DONE; all advance only on sample_en_i=1 cycles except commands.
REQ-017 IDLE: arm_i -> latch config (pre=min(pre_cnt_i, DEPTH-1)), wptr=0, go FILL (ARMED if pre=0).
REQ-018 FILL: write each sample, increment wptr modulo DEPTH; after pre samples -> ARMED.
REQ-019 ARMED: write each sample (wrap-around); trigger evaluated on current sample; hit -> store trig_addr=wptr, go POST.
REQ-020 Channel match: level = trig_i[k]==pol; edge = trig_i[k]==pol and previous qualified sample !=pol; previous sample register reset to 0 at arm.
REQ-021 trig_en_i all zero: trigger fires on first ARMED sample.
REQ-022 POST: write until DEPTH total samples stored after trigger window (DEPTH-pre-1 post samples), then DONE.
REQ-023 Trigger sample is written; triggered_o=1 from POST entry until next arm/abort/reset.
REQ-024 DONE: done_o=1; stream DEPTH samples oldest first from (trig_addr-pre) mod DEPTH; rd_last_o on final sample; afterwards readout idles, done_o stays 1.
REQ-025 Readout handshake: rd_data_o stable while rd_valid_o=1 and rd_ready_i=0; transfer on valid&ready; RAM read latency 1 cycle hidden by one-entry prefetch, sustaining 1 sample/cycle.
REQ-026 arm_i in DONE re-arms (as REQ-017), discarding unread data; arm_i in FILL/ARMED/POST ignored.
REQ-027 abort_i in any state -> IDLE next cycle, rd_valid_o=0; abort wins over simultaneous arm_i.
REQ-028 busy_o=1 in FILL, ARMED, POST.
REQ-029 Config inputs sampled only at arm; changes mid-capture have no effect.

Reset
REQ-030 On rst_n_i=0: state IDLE, all status outputs 0, rd_valid_o=0, rd_last_o=0, trig_pos_o=0, rd_data_o=0, pointers 0; buffer contents undefined.
REQ-031 Reset asserted mid-capture or mid-readout aborts without any further write or transfer.

Structure
REQ-032 Shared package sig_capture_pkg holds state enum and DEPTH/width limits.
REQ-033 One sub-module cap_ram: simple dual-port RAM, DEPTH x DATA_W, 1-cycle registered read, no reset, inferable to block RAM.

Verification (DEPTH=16, DATA_W=8, TRIG_W=2, data_i=sample counter)
REQ-034 pre=4, ch0 rising edge, trig at sample 20 -> readout 16..31, trig_pos_o=4, rd_last_o on 31.
REQ-035 pre=0, trig_en=0 -> triggers first sample after arm; readout 16 consecutive values from arm point.
REQ-036 rd_ready_i toggled 1/0 randomly -> identical 16-value sequence, no drop or duplicate.
REQ-037 abort_i during ARMED, then arm_i -> IDLE one cycle, busy_o=0, fresh capture correct.
REQ-038 sample_en_i every 3rd cycle, pre=15, AND of ch0 high level & ch1 low -> captured values advance by 1 per strobe, trigger sample at index 15.
REQ-039 rst_n_i low during POST -> all outputs 0 within same cycle; later arm works normally.
